// File: rtl/grid_sprite_renderer.sv
// Tile-grid sprite renderer: maps raster position to a grid cell, fetches the cell's
// sprite texel from an external ROM and composites transparency, animation and cursor border.
module grid_sprite_renderer #(
    parameter int          TILE_W      = 32,
    parameter int          TILE_H      = 32,
    parameter int          GRID_COLS   = 13,
    parameter int          GRID_ROWS   = 8,
    parameter int          ORIGIN_X    = 0,
    parameter int          ORIGIN_Y    = 0,
    parameter int          ROM_LATENCY = 2,
    parameter int          ANIM_PERIOD = 15,
    parameter logic [15:0] ANIM_MASK   = 16'h0300,
    parameter logic [11:0] BG_COLOR    = 12'h070,
    parameter logic [11:0] OUT_COLOR   = 12'hFFF,
    parameter logic [11:0] KEY_COLOR   = 12'hF0F,
    parameter logic [11:0] HL_COLOR    = 12'hFF0,
    parameter int          HL_WIDTH    = 2
) (
    input  logic                                        pixel_clk_in,
    input  logic                                        rst_in,
    input  logic [10:0]                                 hcount,
    input  logic [9:0]                                  vcount,
    input  logic                                        frame_tick,
    input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][3:0]    object_grid,
    input  logic                                        cursor_valid,
    input  logic [3:0]                                  cursor_col,
    input  logic [2:0]                                  cursor_row,
    output logic [4+$clog2(TILE_H)+$clog2(TILE_W):0]    sprite_addr,
    input  logic [11:0]                                 sprite_data,
    output logic [11:0]                                 pixel_out,
    output logic                                        pixel_in_grid
);
    localparam int TXW = $clog2(TILE_W);
    localparam int TYW = $clog2(TILE_H);
    localparam int CW  = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int RW  = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int ACW = $clog2(ANIM_PERIOD + 1);
    localparam int AW  = 5 + TYW + TXW;

    localparam logic [11:0]    X_LO   = 12'(ORIGIN_X);
    localparam logic [11:0]    X_HI   = 12'(ORIGIN_X + GRID_COLS * TILE_W);
    localparam logic [10:0]    Y_LO   = 11'(ORIGIN_Y);
    localparam logic [10:0]    Y_HI   = 11'(ORIGIN_Y + GRID_ROWS * TILE_H);
    localparam logic [TXW-1:0] HLX_LO = TXW'(HL_WIDTH);
    localparam logic [TXW-1:0] HLX_HI = TXW'(TILE_W - HL_WIDTH);
    localparam logic [TYW-1:0] HLY_LO = TYW'(HL_WIDTH);
    localparam logic [TYW-1:0] HLY_HI = TYW'(TILE_H - HL_WIDTH);

    logic [11:0]     dx;
    logic [10:0]     dy;
    logic [11-TXW:0] col_full;
    logic [10-TYW:0] row_full;

    logic            vld_a_q, ing_a_q, hl_a_q;
    logic            ing_d, hl_d;
    logic [CW-1:0]   col_a_q, col_d;
    logic [RW-1:0]   row_a_q, row_d;
    logic [TXW-1:0]  tx_a_q, tx_d;
    logic [TYW-1:0]  ty_a_q, ty_d;

    logic [3:0]      type_b;
    logic            frm_b;
    logic [AW-1:0]   addr_d, sprite_addr_q;
    logic [3:0]      flg_d;
    // flag word: {valid, in_grid, highlight, empty_cell}
    logic [3:0]      flg_q [ROM_LATENCY+1];
    logic [3:0]      flg_out;

    logic [11:0]     pix_d, pixel_out_q;
    logic            pig_d, pixel_in_grid_q;
    logic [ACW-1:0]  anim_cnt_q;
    logic            anim_frame_q;

    assign dx       = {1'b0, hcount} - X_LO;
    assign dy       = {1'b0, vcount} - Y_LO;
    assign col_full = dx[11:TXW];
    assign row_full = dy[10:TYW];
    assign flg_out  = flg_q[ROM_LATENCY];

    always_comb begin
        ing_d = ({1'b0, hcount} >= X_LO) && ({1'b0, hcount} < X_HI) &&
                ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} < Y_HI);
        tx_d  = dx[TXW-1:0];
        ty_d  = dy[TYW-1:0];
        hl_d  = cursor_valid && ing_d &&
                (col_full == (12-TXW)'(cursor_col)) &&
                (row_full == (11-TYW)'(cursor_row)) &&
                ((tx_d < HLX_LO) || (tx_d >= HLX_HI) || (ty_d < HLY_LO) || (ty_d >= HLY_HI));
        // zeroed outside the grid so the cell lookup below never indexes past the array
        col_d = ing_d ? col_full[CW-1:0] : '0;
        row_d = ing_d ? row_full[RW-1:0] : '0;
    end

    always_comb begin
        type_b = object_grid[row_a_q][col_a_q];
        frm_b  = ANIM_MASK[type_b] & anim_frame_q;
        addr_d = ing_a_q ? {type_b, frm_b, ty_a_q, tx_a_q} : '0;
        flg_d  = {vld_a_q, ing_a_q, hl_a_q, (type_b == 4'd0)};
    end

    always_comb begin
        pix_d = '0;
        pig_d = 1'b0;
        if (flg_out[3]) begin
            pig_d = flg_out[2];
            if (!flg_out[2])                 pix_d = OUT_COLOR;
            else if (flg_out[1])             pix_d = HL_COLOR;
            else if (flg_out[0])             pix_d = BG_COLOR;
            else if (sprite_data == KEY_COLOR) pix_d = BG_COLOR;
            else                             pix_d = sprite_data;
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_a_q         <= 1'b0;
            ing_a_q         <= 1'b0;
            hl_a_q          <= 1'b0;
            col_a_q         <= '0;
            row_a_q         <= '0;
            tx_a_q          <= '0;
            ty_a_q          <= '0;
            sprite_addr_q   <= '0;
            for (int i = 0; i <= ROM_LATENCY; i++) flg_q[i] <= '0;
            pixel_out_q     <= '0;
            pixel_in_grid_q <= 1'b0;
            anim_cnt_q      <= '0;
            anim_frame_q    <= 1'b0;
        end else begin
            vld_a_q         <= 1'b1;
            ing_a_q         <= ing_d;
            hl_a_q          <= hl_d;
            col_a_q         <= col_d;
            row_a_q         <= row_d;
            tx_a_q          <= tx_d;
            ty_a_q          <= ty_d;
            sprite_addr_q   <= addr_d;
            flg_q[0]        <= flg_d;
            for (int i = 1; i <= ROM_LATENCY; i++) flg_q[i] <= flg_q[i-1];
            pixel_out_q     <= pix_d;
            pixel_in_grid_q <= pig_d;
            if (frame_tick) begin
                if (anim_cnt_q == ACW'(ANIM_PERIOD - 1)) begin
                    anim_cnt_q   <= '0;
                    anim_frame_q <= ~anim_frame_q;
                end else begin
                    anim_cnt_q   <= anim_cnt_q + 1'b1;
                end
            end
        end
    end

    assign sprite_addr   = sprite_addr_q;
    assign pixel_out     = pixel_out_q;
    assign pixel_in_grid = pixel_in_grid_q;
endmodule

// File: tb/tb_grid_sprite_renderer.sv
// Scoreboard bench for grid_sprite_renderer with a 2-stage sprite ROM model.
module tb_grid_sprite_renderer;
    logic                   clk = 1'b0;
    logic                   rst_in = 1'b1;
    logic [10:0]            hcount = '0;
    logic [9:0]             vcount = '0;
    logic                   frame_tick = 1'b0;
    logic [7:0][12:0][3:0]  object_grid = '0;
    logic                   cursor_valid = 1'b0;
    logic [3:0]             cursor_col = '0;
    logic [2:0]             cursor_row = '0;
    logic [14:0]            sprite_addr;
    logic [11:0]            sprite_data = '0;
    logic [11:0]            rom_s1 = '0;
    logic [11:0]            pixel_out;
    logic                   pixel_in_grid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int id = 0;

    typedef struct { int chk; int id; logic [11:0] pix; logic ing; } pexp_t;
    typedef struct { int chk; int id; logic [14:0] addr; } aexp_t;
    pexp_t pq[$];
    aexp_t aq[$];

    grid_sprite_renderer #(.ANIM_PERIOD(3)) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_in),
        .hcount       (hcount),
        .vcount       (vcount),
        .frame_tick   (frame_tick),
        .object_grid  (object_grid),
        .cursor_valid (cursor_valid),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .sprite_addr  (sprite_addr),
        .sprite_data  (sprite_data),
        .pixel_out    (pixel_out),
        .pixel_in_grid(pixel_in_grid)
    );

    always #5 clk = ~clk;

    // ROM: texel is the low 12 address bits, except tx==31 returns the key colour
    function automatic logic [11:0] rom_f(input logic [14:0] a);
        return (a[4:0] == 5'd31) ? 12'hF0F : a[11:0];
    endfunction

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rom_s1      <= rom_f(sprite_addr);
        sprite_data <= rom_s1;
    end

    always @(negedge clk) begin : monitor
        pexp_t e;
        aexp_t a;
        while (pq.size() > 0 && pq[0].chk <= cyc) begin
            e = pq.pop_front();
            checks++;
            if (e.chk < cyc) begin
                failures++;
                $display("FAIL pix#%0d missed slot %0d (now %0d)", e.id, e.chk, cyc);
            end else if (pixel_out !== e.pix || pixel_in_grid !== e.ing) begin
                failures++;
                $display("FAIL pix#%0d pixel_out=%h in_grid=%b expected %h %b",
                         e.id, pixel_out, pixel_in_grid, e.pix, e.ing);
            end
        end
        while (aq.size() > 0 && aq[0].chk <= cyc) begin
            a = aq.pop_front();
            checks++;
            if (a.chk < cyc) begin
                failures++;
                $display("FAIL addr#%0d missed slot %0d (now %0d)", a.id, a.chk, cyc);
            end else if (sprite_addr !== a.addr) begin
                failures++;
                $display("FAIL addr#%0d sprite_addr=%h expected %h", a.id, sprite_addr, a.addr);
            end
        end
    end

    // Called at a falling edge; the sample is taken at the next rising edge S.
    task automatic setpx(input int h, input int v, input logic [11:0] ep, input logic ei,
                         input bit ca, input logic [14:0] ea, input bit zpre);
        int s;
        pexp_t p;
        aexp_t a;
        hcount = h[10:0];
        vcount = v[9:0];
        s = cyc + 1;
        id++;
        if (zpre) begin
            for (int i = 0; i < 4; i++) begin
                p.chk = s + i; p.id = id; p.pix = '0; p.ing = 1'b0;
                pq.push_back(p);
            end
        end
        p.chk = s + 4; p.id = id; p.pix = ep; p.ing = ei;
        pq.push_back(p);
        if (ca) begin
            a.chk = s + 1; a.id = id; a.addr = ea;
            aq.push_back(a);
        end
    endtask

    task automatic drive(input int h, input int v, input logic [11:0] ep, input logic ei);
        @(negedge clk);
        setpx(h, v, ep, ei, 1'b0, '0, 1'b0);
    endtask

    task automatic drive_a(input int h, input int v, input logic [11:0] ep, input logic ei,
                           input logic [14:0] ea);
        @(negedge clk);
        setpx(h, v, ep, ei, 1'b1, ea, 1'b0);
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (pixel_out !== 12'h000 || pixel_in_grid !== 1'b0 || sprite_addr !== 15'h0) begin
            failures++;
            $display("FAIL %s pixel_out=%h in_grid=%b sprite_addr=%h expected all zero",
                     nm, pixel_out, pixel_in_grid, sprite_addr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        object_grid[2][3]  = 4'd4;
        object_grid[0][1]  = 4'd9;
        object_grid[1][1]  = 4'd5;
        object_grid[3][12] = 4'd15;

        repeat (3) @(negedge clk);
        chk_zero("reset_state");

        @(negedge clk);
        rst_in = 1'b0;
        setpx(0, 0, 12'h070, 1'b1, 1'b0, '0, 1'b1);
        drive(1, 0, 12'h070, 1'b1);
        drive(5, 5, 12'h070, 1'b1);
        drive(416, 5, 12'hFFF, 1'b0);
        drive(10, 256, 12'hFFF, 1'b0);
        drive(415, 255, 12'h070, 1'b1);

        drive_a(103, 73, 12'h127, 1'b1, 15'h2127);
        drive_a(99, 73, 12'h123, 1'b1, 15'h2123);
        drive_a(127, 73, 12'h070, 1'b1, 15'h213F);
        drive_a(386, 100, 12'h882, 1'b1, 15'h7882);

        drive_a(37, 6, 12'h8C5, 1'b1, 15'h48C5);
        tick();
        drive_a(37, 6, 12'h8C5, 1'b1, 15'h48C5);
        tick();
        drive_a(37, 6, 12'h8C5, 1'b1, 15'h48C5);
        tick();
        drive_a(37, 6, 12'hCC5, 1'b1, 15'h4CC5);
        drive_a(103, 73, 12'h127, 1'b1, 15'h2127);
        tick(); tick(); tick();
        drive_a(37, 6, 12'h8C5, 1'b1, 15'h48C5);
        drive_a(103, 73, 12'h127, 1'b1, 15'h2127);

        @(negedge clk);
        cursor_valid = 1'b1; cursor_col = 4'd1; cursor_row = 3'd1;
        drive(32, 48, 12'hFF0, 1'b1);
        drive(33, 48, 12'hFF0, 1'b1);
        drive(62, 48, 12'hFF0, 1'b1);
        drive(63, 48, 12'hFF0, 1'b1);
        drive(48, 32, 12'hFF0, 1'b1);
        drive(48, 33, 12'hFF0, 1'b1);
        drive(48, 62, 12'hFF0, 1'b1);
        drive(48, 63, 12'hFF0, 1'b1);
        drive_a(48, 48, 12'hA10, 1'b1, 15'h2A10);
        drive(34, 48, 12'hA02, 1'b1);
        drive(31, 48, 12'h070, 1'b1);
        drive(64, 48, 12'h070, 1'b1);
        @(negedge clk);
        cursor_col = 4'd13;
        drive(32, 48, 12'hA00, 1'b1);
        @(negedge clk);
        cursor_valid = 1'b0; cursor_col = 4'd1;
        drive(32, 48, 12'hA00, 1'b1);

        tick(); tick(); tick();
        drive_a(37, 6, 12'hCC5, 1'b1, 15'h4CC5);
        drive(103, 73, 12'h127, 1'b1);
        drive(37, 6, 12'hCC5, 1'b1);
        drive(99, 73, 12'h123, 1'b1);
        @(negedge clk);
        #2;
        pq.delete();
        aq.delete();
        rst_in = 1'b1;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst_in = 1'b0;
        setpx(37, 6, 12'h8C5, 1'b1, 1'b1, 15'h48C5, 1'b1);
        drive(99, 73, 12'h123, 1'b1);

        for (int i = 0; i < 20 && (pq.size() > 0 || aq.size() > 0); i++) @(negedge clk);
        checks++;
        if (pq.size() > 0 || aq.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0", pq.size() + aq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
